// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, start-edge hunt, mid-bit sampling, framing check.
// Latency: o_RX_DV about 9.5 bit periods + 3 clocks after the start-bit falling edge.
// No backpressure: o_RX_Byte is overwritten by the next good frame; DV/Frame_Err are 1-cycle pulses.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Rst_L      synchronous active-low reset
//   i_RX_Serial  asynchronous serial line, idle high
//   o_RX_DV      1-cycle pulse, o_RX_Byte holds a new byte
//   o_RX_Byte    last correctly framed byte
//   o_Frame_Err  1-cycle pulse, stop bit sampled low
//   o_Busy       high whenever the receiver is not idle
// Optional build macro: UART_RX_MAJORITY_EN (3-sample majority vote at every sample decision).
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Frame_Err,
    output logic       o_Busy
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_byte, w_byte_nxt;
    logic            r_dv, w_dv_nxt;
    logic            r_ferr, w_ferr_nxt;
    logic            r_rx_meta, r_rx_s;
    logic            w_smp;

    // Synchronizer presets high so a reset never looks like a start edge.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_RX_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Vote over the last three synchronized samples; one bad clock is outvoted.
    logic [2:0] r_vote;
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) r_vote <= 3'b111;
        else          r_vote <= {r_vote[1:0], r_rx_s};
    end
    assign w_smp = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);
`else
    assign w_smp = r_rx_s;
`endif

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_byte  <= w_byte_nxt;
            r_dv    <= w_dv_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte;
        w_dv_nxt    = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!r_rx_s) w_state_nxt = ST_START;
            end
            ST_START: begin
                // Re-check the line half a bit in so short glitches are rejected.
                if (r_cnt == HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_smp ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_smp;
                    if (r_idx == 3'd7) w_state_nxt = ST_STOP;
                    else               w_idx_nxt   = r_idx + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    if (w_smp) begin
                        w_byte_nxt  = r_shift;
                        w_dv_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not produce repeated errors.
                if (r_rx_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_RX_DV     = r_dv;
    assign o_RX_Byte   = r_byte;
    assign o_Frame_Err = r_ferr;
    assign o_Busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    logic       clk;
    logic       rst_n;
    logic       rx1, rx2;
    logic       dv1, dv2, ferr1, ferr2, busy1, busy2;
    logic [7:0] byte1, byte2;

    int n_cmp  = 0;
    int n_fail = 0;
    int dv_cnt1 = 0, ferr_cnt1 = 0, dv_cnt2 = 0, ferr_cnt2 = 0;
    logic prev_dv1 = 1'b0, prev_ferr1 = 1'b0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int s_dv, s_ferr;

    uart_rx #(.CLKS_PER_BIT(16)) u_dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx1),
        .o_RX_DV(dv1), .o_RX_Byte(byte1), .o_Frame_Err(ferr1), .o_Busy(busy1)
    );

    // At 16 clocks/bit a 2-clock period error drifts past half a bit by the
    // stop bit, so bit-period tolerance is exercised on a 64 clocks/bit instance.
    uart_rx #(.CLKS_PER_BIT(64)) u_dut_tol (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx2),
        .o_RX_DV(dv2), .o_RX_Byte(byte2), .o_Frame_Err(ferr2), .o_Busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx1 = v;
    endtask

    // Frame: start, 8 data LSB first, stop. Optional 1-clock inverted glitch
    // at the centre of frame position glitch_k (0 = start ... 9 = stop).
    task automatic send_frame(input bit sel, input logic [7:0] b, input int period,
                              input logic stop_v, input int glitch_k);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < period; c++) begin
                drive(sel, (k == glitch_k && c == period / 2) ? ~fr[k] : fr[k]);
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitors: pop the expected byte on every DV pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv1) begin
                dv_cnt1++;
                if (q1.size() == 0) check("dut_unexpected_dv", 32'(dv1), 32'd0);
                else                check("dut_rx_byte", 32'(byte1), 32'(q1.pop_front()));
                check("dut_dv_width", 32'(prev_dv1), 32'd0);
                check("dut_dv_ferr_excl", 32'(ferr1), 32'd0);
            end
            if (ferr1) begin
                ferr_cnt1++;
                check("dut_ferr_width", 32'(prev_ferr1), 32'd0);
            end
            if (dv2) begin
                dv_cnt2++;
                if (q2.size() == 0) check("tol_unexpected_dv", 32'(dv2), 32'd0);
                else                check("tol_rx_byte", 32'(byte2), 32'(q2.pop_front()));
            end
            if (ferr2) ferr_cnt2++;
        end
        prev_dv1   = dv1;
        prev_ferr1 = ferr1;
    end

    initial begin
        rst_n = 1'b0;
        rx1   = 1'b1;
        rx2   = 1'b1;
        idle(4);
        check("reset_dv",   32'(dv1),   32'd0);
        check("reset_ferr", 32'(ferr1), 32'd0);
        check("reset_byte", 32'(byte1), 32'h00);
        check("reset_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        idle(20);

        // Single ideal frame
        q1.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 16, 1'b1, -1);
        idle(4);
        check("a5_dv_count",   32'(dv_cnt1),   32'd1);
        check("a5_ferr_count", 32'(ferr_cnt1), 32'd0);
        check("a5_busy_after", 32'(busy1),     32'd0);

        // Back-to-back frames, no idle gap
        q1.push_back(8'h00); q1.push_back(8'hFF); q1.push_back(8'h3C);
        send_frame(1'b0, 8'h00, 16, 1'b1, -1);
        send_frame(1'b0, 8'hFF, 16, 1'b1, -1);
        send_frame(1'b0, 8'h3C, 16, 1'b1, -1);
        idle(20);
        check("b2b_dv_count", 32'(dv_cnt1), 32'd4);
        check("b2b_q_empty",  32'(q1.size()), 32'd0);

        // 3-clock glitch on idle line
        s_dv = dv_cnt1; s_ferr = ferr_cnt1;
        rx1 = 1'b0; idle(3); rx1 = 1'b1; idle(40);
        check("glitch_no_dv",   32'(dv_cnt1 - s_dv),     32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt1 - s_ferr), 32'd0);
        check("glitch_idle",    32'(busy1),              32'd0);

        // Framing error then break for 40 bit times
        s_dv = dv_cnt1; s_ferr = ferr_cnt1;
        send_frame(1'b0, 8'h55, 16, 1'b0, -1);
        idle(40 * 16);
        check("break_one_ferr", 32'(ferr_cnt1 - s_ferr), 32'd1);
        check("break_no_dv",    32'(dv_cnt1 - s_dv),     32'd0);
        check("break_byte_held", 32'(byte1),             32'h3C);
        rx1 = 1'b1;
        idle(32);
        q1.push_back(8'h81);
        send_frame(1'b0, 8'h81, 16, 1'b1, -1);
        idle(20);
        check("after_break_dv", 32'(dv_cnt1 - s_dv),     32'd1);
        check("after_break_ferr", 32'(ferr_cnt1 - s_ferr), 32'd1);

        // Bit-period tolerance: +2 and -2 clocks
        q2.push_back(8'hC3); q2.push_back(8'hC3);
        send_frame(1'b1, 8'hC3, 66, 1'b1, -1);
        idle(40);
        send_frame(1'b1, 8'hC3, 62, 1'b1, -1);
        idle(40);
        check("tol_dv_count",   32'(dv_cnt2),   32'd2);
        check("tol_ferr_count", 32'(ferr_cnt2), 32'd0);

        // Reset during data bit 4 of frame F0 (bits 4..7 and stop high, so
        // the line stays idle after reset)
        s_dv = dv_cnt1; s_ferr = ferr_cnt1;
        rx1 = 1'b0; idle(5 * 16);
        rx1 = 1'b1; idle(8);
        rst_n = 1'b0;
        idle(1);
        check("midrst_dv",   32'(dv1),   32'd0);
        check("midrst_ferr", 32'(ferr1), 32'd0);
        check("midrst_byte", 32'(byte1), 32'h00);
        check("midrst_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        idle(7 + 4 * 16 + 32);
        check("midrst_no_dv",   32'(dv_cnt1 - s_dv),     32'd0);
        check("midrst_no_ferr", 32'(ferr_cnt1 - s_ferr), 32'd0);
        q1.push_back(8'h7E);
        send_frame(1'b0, 8'h7E, 16, 1'b1, -1);
        idle(20);
        check("midrst_7e_dv", 32'(dv_cnt1 - s_dv), 32'd1);

`ifdef UART_RX_MAJORITY_EN
        // 1-clock inverted glitch at a mid-bit sample point is outvoted
        s_dv = dv_cnt1;
        q1.push_back(8'h5A);
        send_frame(1'b0, 8'h5A, 16, 1'b1, 3);
        idle(20);
        check("vote_dv", 32'(dv_cnt1 - s_dv), 32'd1);
`endif

        check("final_q1_empty", 32'(q1.size()), 32'd0);
        check("final_q2_empty", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
